// File: rtl/ysyx_22040386_csr_file_pkg.sv
// Shared CSR definitions: addresses, state encodings and mstatus field positions.
// Decode imports this package as well so both stages agree on the encodings.
package ysyx_22040386_csr_file_pkg;

  localparam int unsigned CSR_XLEN = 64;
  localparam logic [63:0] CSR_MSTATUS_RST = 64'h0000_000a_0000_1800;
  localparam logic [63:0] CSR_ECALL_CAUSE = 64'd11;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hb00;

  typedef enum logic [2:0] {
    CSR_STATE_IDLE  = 3'd0,
    CSR_STATE_CSRRS = 3'd1,
    CSR_STATE_CSRRW = 3'd2,
    CSR_STATE_ECALL = 3'd3,
    CSR_STATE_MRET  = 3'd4
  } csr_state_e;

  localparam int unsigned MSTATUS_MIE     = 3;
  localparam int unsigned MSTATUS_MPIE    = 7;
  localparam int unsigned MSTATUS_MPP_LO  = 11;
  localparam int unsigned MSTATUS_MPP_HI  = 12;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE: csr_implemented = 1'b1;
      default:                                   csr_implemented = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040386_csr_file.sv
// Machine-mode CSR file with ecall/mret trap sequencing and a free-running mcycle.
// Reads are combinational and return the pre-write value; state commits on the clock edge.
module ysyx_22040386_csr_file
  import ysyx_22040386_csr_file_pkg::*;
#(
  parameter int unsigned XLEN        = CSR_XLEN,
  parameter logic [XLEN-1:0] MSTATUS_RST = CSR_MSTATUS_RST,
  parameter logic [XLEN-1:0] ECALL_CAUSE = CSR_ECALL_CAUSE
) (
  input  logic            i_CSR_clk,
  input  logic            i_CSR_rst,
  input  logic            i_CSR_valid,
  input  logic            i_CSR_ren,
  input  logic            i_CSR_wen,
  input  logic [2:0]      i_CSR_state,
  input  logic [11:0]     i_CSR_raddr,
  input  logic [11:0]     i_CSR_waddr,
  input  logic [XLEN-1:0] i_CSR_wr_data,
  input  logic [XLEN-1:0] i_CSR_pc,
  output logic [XLEN-1:0] o_CSR_rd_data,
  output logic            o_CSR_redirect,
  output logic [XLEN-1:0] o_CSR_target,
  output logic            o_CSR_illegal
);

  logic [XLEN-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mcycle;
  logic [XLEN-1:0] rd_value, old_wvalue, new_wvalue;
  logic            do_ecall, do_mret, do_write;
  csr_state_e      state;

  assign state = csr_state_e'(i_CSR_state);

  always_comb begin
    rd_value = '0;
    case (i_CSR_raddr)
      CSR_MSTATUS:  rd_value = mstatus;
      CSR_MIE:      rd_value = mie;
      CSR_MTVEC:    rd_value = mtvec;
      CSR_MSCRATCH: rd_value = mscratch;
      CSR_MEPC:     rd_value = mepc;
      CSR_MCAUSE:   rd_value = mcause;
      CSR_MCYCLE:   rd_value = mcycle;
      default:      rd_value = '0;
    endcase
  end

  // csrrs needs the current value at the write address, which may differ from raddr
  always_comb begin
    old_wvalue = '0;
    case (i_CSR_waddr)
      CSR_MSTATUS:  old_wvalue = mstatus;
      CSR_MIE:      old_wvalue = mie;
      CSR_MTVEC:    old_wvalue = mtvec;
      CSR_MSCRATCH: old_wvalue = mscratch;
      CSR_MEPC:     old_wvalue = mepc;
      CSR_MCAUSE:   old_wvalue = mcause;
      CSR_MCYCLE:   old_wvalue = mcycle;
      default:      old_wvalue = '0;
    endcase
  end

  always_comb begin
    do_ecall   = i_CSR_valid && (state == CSR_STATE_ECALL);
    do_mret    = i_CSR_valid && (state == CSR_STATE_MRET);
    new_wvalue = (state == CSR_STATE_CSRRS) ? (old_wvalue | i_CSR_wr_data) : i_CSR_wr_data;
    do_write   = i_CSR_valid && i_CSR_wen && csr_implemented(i_CSR_waddr) &&
                 ((state == CSR_STATE_CSRRW) ||
                  ((state == CSR_STATE_CSRRS) && (i_CSR_wr_data != '0)));

    o_CSR_rd_data  = i_CSR_ren ? rd_value : '0;
    o_CSR_illegal  = (i_CSR_ren && !csr_implemented(i_CSR_raddr)) ||
                     (i_CSR_wen && !csr_implemented(i_CSR_waddr));
    o_CSR_redirect = do_ecall || do_mret;
    o_CSR_target   = do_ecall ? mtvec : (do_mret ? mepc : '0);
  end

  // Trap updates and software writes are mutually exclusive because do_write requires a csrrs/csrrw state
  always_ff @(posedge i_CSR_clk) begin
    if (i_CSR_rst) begin
      mstatus  <= MSTATUS_RST;
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
    end else begin
      mcycle <= (do_write && (i_CSR_waddr == CSR_MCYCLE)) ? new_wvalue : mcycle + 1'b1;
      if (do_ecall) begin
        mepc                                  <= {i_CSR_pc[XLEN-1:2], 2'b00};
        mcause                                <= ECALL_CAUSE;
        mstatus[MSTATUS_MPIE]                 <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]                  <= 1'b0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end else if (do_mret) begin
        mstatus[MSTATUS_MIE]                  <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE]                 <= 1'b1;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      end else if (do_write) begin
        case (i_CSR_waddr)
          CSR_MSTATUS:  mstatus  <= new_wvalue;
          CSR_MIE:      mie      <= new_wvalue;
          CSR_MTVEC:    mtvec    <= {new_wvalue[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch <= new_wvalue;
          CSR_MEPC:     mepc     <= {new_wvalue[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= new_wvalue;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_csr_file.sv
// Directed self-checking bench for the CSR file: reset, read/write, traps, mcycle and illegal accesses.
module tb_ysyx_22040386_csr_file;

  logic        clk, rst, valid, ren, wen;
  logic [2:0]  state;
  logic [11:0] raddr, waddr;
  logic [63:0] wr_data, pc, rd_data, target;
  logic        redirect, illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RST_MSTATUS = 64'h0000_000a_0000_1800;

  ysyx_22040386_csr_file dut (
    .i_CSR_clk      (clk),
    .i_CSR_rst      (rst),
    .i_CSR_valid    (valid),
    .i_CSR_ren      (ren),
    .i_CSR_wen      (wen),
    .i_CSR_state    (state),
    .i_CSR_raddr    (raddr),
    .i_CSR_waddr    (waddr),
    .i_CSR_wr_data  (wr_data),
    .i_CSR_pc       (pc),
    .o_CSR_rd_data  (rd_data),
    .o_CSR_redirect (redirect),
    .o_CSR_target   (target),
    .o_CSR_illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] st,
                       input logic [11:0] ra, input logic [11:0] wa,
                       input logic [63:0] wd, input logic [63:0] p);
    valid = v; ren = r; wen = w; state = st;
    raddr = ra; waddr = wa; wr_data = wd; pc = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_read(input logic [11:0] ra);
    drive(1'b0, 1'b1, 1'b0, 3'd0, ra, 12'h0, 64'h0, 64'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 12'h0, 12'h0, 64'h0, 64'h0);
    tick();
    rst = 1'b0;
    checks++;
    if (redirect !== 1'b0 || target !== 64'h0 || illegal !== 1'b0 || rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: redirect=%b target=%h illegal=%b rd=%h expected 0,0,0,0",
               redirect, target, illegal, rd_data);
    end
    drive(1'b1, 1'b1, 1'b1, 3'd1, 12'h300, 12'h300, 64'h0, 64'h0);
    checks++;
    if (rd_data !== RST_MSTATUS || illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mstatus: rd=%h illegal=%b expected %h,0", rd_data, illegal, RST_MSTATUS);
    end
    tick();
    idle_read(12'h300);
    checks++;
    if (rd_data !== RST_MSTATUS) begin
      errors++;
      $display("[TB] FAIL csrrs_zero_no_write: rd=%h expected %h", rd_data, RST_MSTATUS);
    end
  endtask

  task automatic test_mtvec();
    drive(1'b1, 1'b1, 1'b1, 3'd2, 12'h305, 12'h305, 64'h8000_0103, 64'h0);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL mtvec_old_value: rd=%h expected 0", rd_data);
    end
    tick();
    idle_read(12'h305);
    checks++;
    if (rd_data !== 64'h8000_0100) begin
      errors++;
      $display("[TB] FAIL mtvec_masked: rd=%h expected 80000100", rd_data);
    end
  endtask

  task automatic test_ecall();
    drive(1'b1, 1'b0, 1'b1, 3'd1, 12'h0, 12'h300, 64'h8, 64'h0);
    tick();
    // ecall carrying a stray write to mscratch; the write must be ignored
    drive(1'b1, 1'b0, 1'b1, 3'd3, 12'h0, 12'h340, 64'h123, 64'h8000_0040);
    checks++;
    if (redirect !== 1'b1 || target !== 64'h8000_0100) begin
      errors++;
      $display("[TB] FAIL ecall_redirect: redirect=%b target=%h expected 1,80000100", redirect, target);
    end
    tick();
    idle_read(12'h341);
    checks++;
    if (rd_data !== 64'h8000_0040 || redirect !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ecall_mepc: rd=%h redirect=%b expected 80000040,0", rd_data, redirect);
    end
    idle_read(12'h342);
    checks++;
    if (rd_data !== 64'd11) begin
      errors++;
      $display("[TB] FAIL ecall_mcause: rd=%h expected b", rd_data);
    end
    idle_read(12'h300);
    checks++;
    if (rd_data !== 64'h0000_000a_0000_1880) begin
      errors++;
      $display("[TB] FAIL ecall_mstatus: rd=%h expected a00001880", rd_data);
    end
    idle_read(12'h340);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL ecall_write_suppressed: rd=%h expected 0", rd_data);
    end
  endtask

  task automatic test_mret();
    drive(1'b1, 1'b0, 1'b0, 3'd4, 12'h0, 12'h0, 64'h0, 64'h0);
    checks++;
    if (redirect !== 1'b1 || target !== 64'h8000_0040) begin
      errors++;
      $display("[TB] FAIL mret_redirect: redirect=%b target=%h expected 1,80000040", redirect, target);
    end
    tick();
    idle_read(12'h300);
    checks++;
    if (rd_data !== 64'h0000_000a_0000_1888) begin
      errors++;
      $display("[TB] FAIL mret_mstatus: rd=%h expected a00001888", rd_data);
    end
  endtask

  task automatic test_gating();
    drive(1'b0, 1'b0, 1'b1, 3'd3, 12'h0, 12'h340, 64'h77, 64'h1234);
    checks++;
    if (redirect !== 1'b0 || target !== 64'h0) begin
      errors++;
      $display("[TB] FAIL stall_redirect: redirect=%b target=%h expected 0,0", redirect, target);
    end
    tick();
    idle_read(12'h341);
    checks++;
    if (rd_data !== 64'h8000_0040) begin
      errors++;
      $display("[TB] FAIL stall_mepc: rd=%h expected 80000040", rd_data);
    end
  endtask

  task automatic test_mcycle();
    logic [63:0] expect_cnt;
    drive(1'b1, 1'b0, 1'b1, 3'd2, 12'h0, 12'hb00, 64'd5, 64'h0);
    tick();
    expect_cnt = 64'd5;
    for (int i = 0; i < 4; i++) begin
      idle_read(12'hb00);
      checks++;
      if (rd_data !== expect_cnt) begin
        errors++;
        $display("[TB] FAIL mcycle_count_%0d: rd=%0d expected %0d", i, rd_data, expect_cnt);
      end
      tick();
      expect_cnt = expect_cnt + 64'd1;
    end
    drive(1'b1, 1'b0, 1'b1, 3'd2, 12'h0, 12'hb00, 64'hffff_ffff_ffff_ffff, 64'h0);
    tick();
    idle_read(12'hb00);
    checks++;
    if (rd_data !== 64'hffff_ffff_ffff_ffff) begin
      errors++;
      $display("[TB] FAIL mcycle_allones: rd=%h expected ffffffffffffffff", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL mcycle_wrap: rd=%h expected 0", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b1, 3'd2, 12'h340, 12'h340, 64'h55, 64'h0);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL rdw_old_value: rd=%h expected 0", rd_data);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd1, 12'h340, 12'h340, 64'ha0, 64'h0);
    checks++;
    if (rd_data !== 64'h55) begin
      errors++;
      $display("[TB] FAIL csrrw_mscratch: rd=%h expected 55", rd_data);
    end
    tick();
    idle_read(12'h340);
    checks++;
    if (rd_data !== 64'hf5) begin
      errors++;
      $display("[TB] FAIL csrrs_mscratch: rd=%h expected f5", rd_data);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 1'b1, 1'b1, 3'd2, 12'h7c0, 12'h7c0, 64'h1, 64'h0);
    checks++;
    if (illegal !== 1'b1 || rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL illegal_addr: illegal=%b rd=%h expected 1,0", illegal, rd_data);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'd2, 12'h344, 12'h344, 64'hffff, 64'h0);
    tick();
    idle_read(12'h344);
    checks++;
    if (rd_data !== 64'h0 || illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mip_readonly: rd=%h illegal=%b expected 0,0", rd_data, illegal);
    end
    idle_read(12'h340);
    checks++;
    if (rd_data !== 64'hf5) begin
      errors++;
      $display("[TB] FAIL illegal_no_state_change: rd=%h expected f5", rd_data);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd3, 12'h0, 12'h0, 64'h0, 64'h1234);
    tick();
    rst = 1'b0;
    idle_read(12'h341);
    checks++;
    if (rd_data !== 64'h0 || redirect !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_vs_ecall: mepc=%h redirect=%b expected 0,0", rd_data, redirect);
    end
    idle_read(12'h300);
    checks++;
    if (rd_data !== RST_MSTATUS) begin
      errors++;
      $display("[TB] FAIL reset_vs_ecall_mstatus: rd=%h expected %h", rd_data, RST_MSTATUS);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 12'h0, 12'h0, 64'h0, 64'h0);
    @(posedge clk);
    #1;
    test_reset();
    test_mtvec();
    test_ecall();
    test_mret();
    test_gating();
    test_mcycle();
    test_back_to_back();
    test_illegal();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
